sram_block_ctrl: RTL and testbench
==================================

# sram_block_ctrl

Initiator-side controller for the 128-bit behavioural block SRAM (`read`/`write`/`addr`/`valueIn`/`valueOut` interface). It accepts single-block write and burst-read requests from the cipher datapath over a valid/ready handshake. It sequences the SRAM strobes with fixed access latencies and returns read blocks over a valid/ready response channel. It sits between the core datapath and the SRAM model and replaces hand-driven strobes with a cycle-accurate master.

## Interface
Parameters:
- READ_LAT, 2: cycles `sram_read` is held per beat; data sampled in the last cycle (≥1)
- WRITE_LAT, 1: cycles `sram_write` is held (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  16  byte address of first block (16-byte aligned)
- req_len  in  4  read burst length minus one (1–16 beats); ignored for writes
- req_data  in  128  write block
- rsp_valid  out  1  read block available
- rsp_ready  in  1  consumer takes block
- rsp_data  out  128  read block
- rsp_last  out  1  final beat of burst
- wr_done  out  1  one-cycle pulse, write completed
- busy  out  1  state ≠ IDLE
- sram_read  out  1  SRAM read strobe
- sram_write  out  1  SRAM write strobe
- sram_addr  out  16  SRAM byte address
- sram_wdata  out  128  SRAM write data (to `valueIn`)
- sram_rdata  in  128  SRAM read data (from `valueOut`)

## Operation
- States: IDLE, WR, RD, RSP.
- IDLE: `req_ready`=1. Accept on `req_valid && req_ready`. Latch addr, len, data. Go to WR if `req_write`, otherwise RD.
- WR: `sram_write`=1, `sram_addr`/`sram_wdata` held stable for WRITE_LAT cycles. Then go to IDLE with `wr_done` pulsed.
- RD: `sram_read`=1 for READ_LAT cycles. On the last cycle, capture `sram_rdata` into `rsp_data`. Then go to RSP.
- RSP: `rsp_valid`=1, data stable until `rsp_ready`.
  - On handshake with beats remaining: addr += 16, beat counter += 1, go to RD.
  - On the final beat (`rsp_last`=1): go to IDLE.
- `sram_read` and `sram_write` are never high together. Both strobes are low in IDLE and RSP, so strobes deassert for at least one cycle between beats.
- Address arithmetic is 16-bit modulo: burst from 0xFFF0 continues at 0x0000.
- `sram_addr[3:0]` is always driven 0.
- `rsp_valid` with `rsp_ready` tied high: throughput is one beat per READ_LAT+1 cycles.

## Timing
- Reset values: `req_ready`=0 while `rst` high. All other outputs 0, state IDLE, counters 0. `req_ready`=1 the first cycle after `rst` falls.
- Request accepted at edge E. Strobe active in cycles E+1 … E+LAT.
- Read: `rsp_valid` first high in cycle E+READ_LAT+1.
- Write: `wr_done` and `req_ready` high in cycle E+WRITE_LAT+1.
- `req_*` inputs are sampled only at the accept edge; later changes have no effect.
- Reset mid-operation: at the next edge strobes drop and `rsp_valid`/`wr_done` are 0. The pending burst is discarded with no partial response.
- `rsp_ready` held low: the controller stalls in RSP indefinitely with no SRAM activity.

## Configuration
- SRAM_CTRL_ALIGN_CHK_EN defined:
  - A request with `req_addr[3:0]` ≠ 0 is accepted but not executed. No strobes are issued.
  - Output `align_err` (1 bit, reset 0) pulses in cycle E+1, and the state stays IDLE.
- Undefined: there is no `align_err` port. `req_addr[3:0]` is ignored (truncated) and the access proceeds at the aligned address.

## Structure
- Package `sram_ctrl_pkg`:
  - state enum `sram_ctrl_state_t` {IDLE, WR, RD, RSP}
  - ADDR_W=16, DATA_W=128, BLOCK_BYTES=16, LEN_W=4
- Sub-module `sram_wait_cnt`: loadable down-counter producing a `done` flag for the strobe-hold window. It is used for both READ_LAT and WRITE_LAT.

## Test plan
- Write 0x0123…3210 at addr 0, then read len=0 at addr 0. Required:
  - `sram_write` high exactly 1 cycle.
  - `rsp_data`=0x0123…3210 with `rsp_last`=1 in cycle E+3.
- Writes to addrs 16 and 32 (all-FF, 0xAABB…2211), then read burst len=1 from 16. Required:
  - Two beats FF…FF then AABB…2211.
  - `sram_addr` 16 then 32, strobe low ≥1 cycle between beats.
- Burst len=1 from 0xFFF0. Required: second beat address 0x0000.
- Hold `rsp_ready`=0 for 10 cycles during a burst. Required:
  - `rsp_data` stable, no strobes during the stall.
  - Burst resumes correctly after release.
- Assert `rst` in the 2nd RD cycle. Required:
  - Next cycle all outputs 0.
  - `req_ready`=1 after release, and a fresh read returns correct data.
- With SRAM_CTRL_ALIGN_CHK_EN, request at addr 0x0005. Required:
  - `align_err` pulses once.
  - No `sram_read`/`sram_write` activity.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared geometry, FSM state type and sizing helper for the
// block SRAM controller.
package sram_ctrl_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 128;
    localparam int BLOCK_BYTES = 16;
    localparam int LEN_W       = 4;
    localparam int BLK_OFS_W   = $clog2(BLOCK_BYTES);
    localparam int BLK_W       = ADDR_W - BLK_OFS_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } sram_ctrl_state_t;

    // Bits needed by a down-counter loaded with (lat_max - 1); never below 1.
    function automatic int lat_cnt_w(input int lat_max);
        return (lat_max <= 2) ? 1 : $clog2(lat_max);
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// sram_wait_cnt: loadable down-counter that times a strobe-hold window.
// done is high while the count sits at zero.
module sram_wait_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/sram_block_ctrl.sv
// sram_block_ctrl: valid/ready master for the 128-bit block SRAM (single-block
// writes, burst reads). Define SRAM_CTRL_ALIGN_CHK_EN to reject misaligned requests.
module sram_block_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              wr_done,
    output logic              busy,
    output logic              sram_read,
    output logic              sram_write,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
`ifdef SRAM_CTRL_ALIGN_CHK_EN
    output logic              align_err,
`endif
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = lat_cnt_w(LAT_MAX);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

    sram_ctrl_state_t state_q, state_d;

    logic [BLK_W-1:0]  blk_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              wr_done_q;

    logic              accept;
    logic              misalign;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_done;
    logic              rsp_take;

    sram_wait_cnt #(
        .CNT_W(CNT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

`ifdef SRAM_CTRL_ALIGN_CHK_EN
    logic align_err_q;

    assign misalign  = (req_addr[BLK_OFS_W-1:0] != '0);
    assign align_err = align_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= accept && misalign;
        end
    end
`else
    // Low address bits are simply truncated to the enclosing block.
    logic unused_ofs;

    assign misalign   = 1'b0;
    assign unused_ofs = ^req_addr[BLK_OFS_W-1:0];
`endif

    assign accept   = req_valid && req_ready;
    assign rsp_take = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        req_ready  = 1'b0;
        sram_read  = 1'b0;
        sram_write = 1'b0;
        rsp_valid  = 1'b0;
        rsp_last   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst && !misalign) begin
                    cnt_load = 1'b1;
                    if (req_write) begin
                        state_d = WR;
                        cnt_val = WR_LOAD;
                    end else begin
                        state_d = RD;
                        cnt_val = RD_LOAD;
                    end
                end
            end
            WR: begin
                sram_write = 1'b1;
                if (cnt_done) begin
                    state_d = IDLE;
                end
            end
            RD: begin
                sram_read = 1'b1;
                if (cnt_done) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                rsp_last  = (beat_q == len_q);
                if (rsp_ready) begin
                    if (beat_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = RD;
                        cnt_load = 1'b1;
                        cnt_val  = RD_LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control: beat counter and write-completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q    <= '0;
            wr_done_q <= 1'b0;
        end else begin
            wr_done_q <= (state_q == WR) && cnt_done;
            if (accept) begin
                beat_q <= '0;
            end else if (rsp_take && !rsp_last) begin
                beat_q <= beat_q + LEN_W'(1);
            end
        end
    end

    // Data: request latch, block address walk, read capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            blk_q   <= req_addr[ADDR_W-1:BLK_OFS_W];
            len_q   <= req_len;
            wdata_q <= req_data;
        end else if (rsp_take && !rsp_last) begin
            blk_q <= blk_q + BLK_W'(1);
        end
        if ((state_q == RD) && cnt_done) begin
            rdata_q <= sram_rdata;
        end
    end

    assign wr_done    = wr_done_q;
    assign busy       = (state_q != IDLE);
    assign sram_addr  = (sram_read || sram_write) ? {blk_q, {BLK_OFS_W{1'b0}}} : '0;
    assign sram_wdata = sram_write ? wdata_q : '0;
    assign rsp_data   = rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_sram_block_ctrl.sv
// tb_sram_block_ctrl: directed, table-driven bench for sram_block_ctrl with a
// behavioural 128-bit block SRAM attached.
module tb_sram_block_ctrl;

    localparam int READ_LAT  = 2;
    localparam int WRITE_LAT = 1;

    localparam logic [127:0] D0  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] DFF = {128{1'b1}};
    localparam logic [127:0] DAA = 128'hAABBCCDDEEFF00998877665544332211;
    localparam logic [127:0] D5  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] D9  = 128'hC0FFEE00123456789ABCDEF00F1E2D3C;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [15:0]  req_addr;
    logic [3:0]   req_len;
    logic [127:0] req_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_last;
    logic         wr_done;
    logic         busy;
    logic         sram_read;
    logic         sram_write;
    logic [15:0]  sram_addr;
    logic [127:0] sram_wdata;
    logic [127:0] sram_rdata;
`ifdef SRAM_CTRL_ALIGN_CHK_EN
    logic         align_err;
`endif

    sram_block_ctrl #(
        .READ_LAT  (READ_LAT),
        .WRITE_LAT (WRITE_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .wr_done    (wr_done),
        .busy       (busy),
        .sram_read  (sram_read),
        .sram_write (sram_write),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
`ifdef SRAM_CTRL_ALIGN_CHK_EN
        .align_err  (align_err),
`endif
        .sram_rdata (sram_rdata)
    );

    // Behavioural SRAM: synchronous write, combinational read while strobed.
    logic [127:0] mem [0:4095];
    always @(posedge clk) begin
        if (sram_write) mem[sram_addr[15:4]] <= sram_wdata;
    end
    assign sram_rdata = sram_read ? mem[sram_addr[15:4]] : {4{32'hDEADBEEF}};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic overlap_seen = 1'b0;
    always @(negedge clk) begin
        if (sram_read && sram_write) overlap_seen <= 1'b1;
    end

    typedef struct {
        string        name;
        bit           wr;
        logic [15:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
        logic [127:0] e0;
        logic [127:0] e1;
        logic [15:0]  a0;
        logic [15:0]  a1;
        int           stall;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input bit wr, input logic [15:0] a, input logic [3:0] l,
                       input logic [127:0] d, input logic [127:0] e0, input logic [127:0] e1,
                       input logic [15:0] a0, input logic [15:0] a1, input int stall);
        vec_t v;
        v.name = nm; v.wr = wr; v.addr = a; v.len = l; v.data = d;
        v.e0 = e0; v.e1 = e1; v.a0 = a0; v.a1 = a1; v.stall = stall;
        vecs.push_back(v);
    endtask

    // Present a request at a negedge, let it be accepted, then scramble req_*.
    task automatic issue(input bit wr, input logic [15:0] a, input logic [3:0] l, input logic [127:0] d);
        check("req_ready_before_req", 128'(req_ready), 128'd1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l; req_data = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_write = ~wr; req_addr = 16'hBEEF; req_len = 4'hA;
        req_data = {4{32'h5EED5EED}};
    endtask

    task automatic do_write(input vec_t v);
        int wcnt;
        int n;
        issue(1'b1, v.addr, v.len, v.data);
        check({v.name, "_sram_addr"}, 128'(sram_addr), 128'(v.a0));
        check({v.name, "_sram_wdata"}, sram_wdata, v.data);
        wcnt = 0;
        n = 0;
        while (!wr_done && n < 20) begin
            if (sram_write) wcnt++;
            @(negedge clk);
            n++;
        end
        check({v.name, "_write_cycles"}, 128'(wcnt), 128'(WRITE_LAT));
        check({v.name, "_wr_done_latency"}, 128'(n), 128'(WRITE_LAT));
        check({v.name, "_ready_at_done"}, 128'(req_ready), 128'd1);
        @(negedge clk);
        check({v.name, "_wr_done_pulse"}, 128'(wr_done), 128'd0);
    endtask

    task automatic do_read(input vec_t v);
        int           n;
        int           rcnt;
        logic [15:0]  la;
        logic [15:0]  ea;
        logic [127:0] ed;
        bit           bad;
        rsp_ready = (v.stall == 0);
        issue(1'b0, v.addr, v.len, '0);
        for (int b = 0; b <= int'(v.len); b++) begin
            ea   = (b == 0) ? v.a0 : v.a1;
            ed   = (b == 0) ? v.e0 : v.e1;
            n    = 0;
            rcnt = 0;
            la   = 16'h0BAD;
            while (!rsp_valid && n < 20) begin
                if (sram_read) begin
                    rcnt++;
                    la = sram_addr;
                end
                @(negedge clk);
                n++;
            end
            check($sformatf("%s_b%0d_latency", v.name, b), 128'(n), 128'(READ_LAT));
            check($sformatf("%s_b%0d_read_cycles", v.name, b), 128'(rcnt), 128'(READ_LAT));
            check($sformatf("%s_b%0d_sram_addr", v.name, b), 128'(la), 128'(ea));
            check($sformatf("%s_b%0d_rsp_data", v.name, b), rsp_data, ed);
            check($sformatf("%s_b%0d_rsp_last", v.name, b), 128'(rsp_last), 128'(b == int'(v.len)));
            check($sformatf("%s_b%0d_strobes_in_rsp", v.name, b), 128'({sram_read, sram_write}), 128'd0);
            if (b == 0 && v.stall > 0) begin
                bad = 1'b0;
                repeat (v.stall) begin
                    @(negedge clk);
                    if (!rsp_valid || rsp_data !== ed || sram_read || sram_write || rsp_last) bad = 1'b1;
                end
                check({v.name, "_stall_hold"}, 128'(bad), 128'd0);
                rsp_ready = 1'b1;
            end
            @(negedge clk);
        end
        check({v.name, "_idle_after"}, 128'({busy, req_ready}), 128'b01);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        req_data = '0; rsp_ready = 1'b1;

        add("w0",      1'b1, 16'h0000, 4'h0, D0,  '0,  '0,  16'h0000, 16'h0000, 0);
        add("r0",      1'b0, 16'h0000, 4'h0, '0,  D0,  '0,  16'h0000, 16'h0000, 0);
        add("w16",     1'b1, 16'h0010, 4'h0, DFF, '0,  '0,  16'h0010, 16'h0000, 0);
        add("w32",     1'b1, 16'h0020, 4'h0, DAA, '0,  '0,  16'h0020, 16'h0000, 0);
        add("burst16", 1'b0, 16'h0010, 4'h1, '0,  DFF, DAA, 16'h0010, 16'h0020, 0);
        add("wtop",    1'b1, 16'hFFF0, 4'h0, D5,  '0,  '0,  16'hFFF0, 16'h0000, 0);
        add("wrap",    1'b0, 16'hFFF0, 4'h1, '0,  D5,  D0,  16'hFFF0, 16'h0000, 0);
        add("stall",   1'b0, 16'h0010, 4'h1, '0,  DFF, DAA, 16'h0010, 16'h0020, 10);
`ifdef SRAM_CTRL_ALIGN_CHK_EN
        add("trunc",   1'b0, 16'h0010, 4'h0, '0,  DFF, '0,  16'h0010, 16'h0000, 0);
`else
        add("trunc",   1'b0, 16'h0015, 4'h0, '0,  DFF, '0,  16'h0010, 16'h0000, 0);
`endif
        add("wlenjunk", 1'b1, 16'h0030, 4'hF, D9, '0,  '0,  16'h0030, 16'h0000, 0);
        add("r48",     1'b0, 16'h0030, 4'h0, '0,  D9,  '0,  16'h0030, 16'h0000, 0);

        repeat (3) @(negedge clk);
        check("reset_ctrl", 128'({req_ready, rsp_valid, rsp_last, wr_done, busy,
                                  sram_read, sram_write, sram_addr}), 128'd0);
        check("reset_data", sram_wdata | rsp_data, 128'd0);
`ifdef SRAM_CTRL_ALIGN_CHK_EN
        check("reset_align_err", 128'(align_err), 128'd0);
`endif
        rst = 1'b0;
        #1;
        check("ready_after_reset", 128'(req_ready), 128'd1);

        foreach (vecs[i]) begin
            if (vecs[i].wr) do_write(vecs[i]);
            else            do_read(vecs[i]);
        end

        // Reset landing in the second read cycle discards the pending beat.
        rsp_ready = 1'b1;
        issue(1'b0, 16'h0020, 4'h0, '0);
        check("midrst_first_rd", 128'(sram_read), 128'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ctrl", 128'({req_ready, rsp_valid, rsp_last, wr_done, busy,
                                   sram_read, sram_write, sram_addr}), 128'd0);
        check("midrst_data", sram_wdata | rsp_data, 128'd0);
        rst = 1'b0;
        #1;
        check("midrst_ready_after", 128'(req_ready), 128'd1);
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || busy || sram_read) bad = 1'b1;
        end
        check("midrst_no_partial", 128'(bad), 128'd0);
        do_read(vecs[1]);

`ifdef SRAM_CTRL_ALIGN_CHK_EN
        begin
            int pulses;
            bad = 1'b0;
            issue(1'b0, 16'h0005, 4'h0, '0);
            check("align_err_e1", 128'(align_err), 128'd1);
            pulses = 0;
            repeat (6) begin
                if (align_err) pulses++;
                if (sram_read || sram_write || busy) bad = 1'b1;
                @(negedge clk);
            end
            check("align_err_pulses", 128'(pulses), 128'd1);
            check("align_no_strobes", 128'(bad), 128'd0);
        end
`endif

        check("no_rd_wr_overlap", 128'(overlap_seen), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
